// File: rtl/i2s_rx.sv
// Purpose : I2S receiver; deserialises left/right words into a signed sample pair.
// Latency : sample_valid and frame_err are asserted 1 clk after the bit slot that completes the word.
// Backpr. : none; sample_l/sample_r hold between sample_valid pulses.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   i2s_bclk/lrclk/sdata- asynchronous I2S inputs (bclk <= clk/4, lrclk 0 = left)
//   sample_l, sample_r  - last complete pair, two's complement, MSB-aligned
//   sample_valid        - 1-clk pulse when a new pair is presented
//   frame_err           - 1-clk pulse on a short word or a right word with no left
// DATA_W must be at least 2 and SYNC_STAGES at least 2.
module i2s_rx #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {SYNC, DELAY, SHIFT, DONE} state_t;

  // Input synchronizers, all cleared in reset.
  logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, sd_sync;
  // Fills with ones after reset; edge detection is held off until both the
  // synchronizer and bclk_d carry real samples, so a bclk that is already
  // high at reset release is not mistaken for a rising edge.
  logic [SYNC_STAGES:0]   prime;
  logic                   bclk_d;
  logic                   bclk_s, ws_s, sd_s, slot, ws_chg;

  state_t                 state, state_nxt;
  logic                   ws_prev;
  logic                   chan, chan_nxt;       // channel of the word in progress
  logic                   have_left;            // left word held, waiting for its right
  logic [DATA_W-1:0]      shreg, shreg_nxt;
  logic [CNT_W-1:0]       bit_cnt, cnt_nxt;
  logic [DATA_W-1:0]      hold;
  logic [DATA_W-1:0]      shift_word, store_word;
  logic [CNT_W-1:0]       shamt;
  logic                   store_en, short_err, pair_en, orphan;

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign ws_s   = ws_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];
  assign slot   = prime[SYNC_STAGES] & bclk_s & ~bclk_d;
  assign ws_chg = ws_s ^ ws_prev;

  assign shift_word = {shreg[DATA_W-2:0], sd_s};
  // Left-justify a short word: the bits received so far move to the MSBs.
  assign shamt      = CNT_W'(DATA_W) - bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      prime     <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
      bclk_d    <= bclk_s;
    end
  end

  always_comb begin
    state_nxt  = state;
    chan_nxt   = chan;
    shreg_nxt  = shreg;
    cnt_nxt    = bit_cnt;
    store_en   = 1'b0;
    store_word = shift_word;
    short_err  = 1'b0;
    if (slot) begin
      case (state)
        SYNC: begin
          // Only a 1->0 ws edge starts reception, so the first word is left.
          if (ws_prev && !ws_s) begin
            state_nxt = DELAY;
            chan_nxt  = 1'b0;
          end
        end
        DELAY: begin
          if (ws_chg) begin
            chan_nxt = ws_s;          // another delay slot: restart on new channel
          end else begin
            shreg_nxt = {{(DATA_W-1){1'b0}}, sd_s};
            cnt_nxt   = CNT_W'(1);
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (ws_chg) begin
            // Word cut short; this slot is the next channel's delay slot.
            store_en   = 1'b1;
            short_err  = 1'b1;
            store_word = shreg << shamt;
            state_nxt  = DELAY;
            chan_nxt   = ws_s;
          end else begin
            shreg_nxt = shift_word;
            if (bit_cnt != CNT_W'(DATA_W)) cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              store_en  = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          // Padding bits of a wide slot are dropped until the channel flips.
          if (ws_chg) begin
            state_nxt = DELAY;
            chan_nxt  = ws_s;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
    pair_en = store_en & chan & have_left;
    orphan  = store_en & chan & ~have_left;
    if (orphan) state_nxt = SYNC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      ws_prev      <= 1'b0;
      chan         <= 1'b0;
      have_left    <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      hold         <= '0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      chan         <= chan_nxt;
      shreg        <= shreg_nxt;
      bit_cnt      <= cnt_nxt;
      sample_valid <= pair_en;
      frame_err    <= short_err | orphan;
      if (slot) ws_prev <= ws_s;
      if (store_en && !chan) begin
        hold      <= store_word;
        have_left <= 1'b1;
      end
      if (pair_en) begin
        sample_l  <= hold;
        sample_r  <= store_word;
        have_left <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Purpose : self-checking bench for i2s_rx (table-driven frames plus corner sequences).
// Latency : checks sample_valid arrives SYNC_STAGES+1 clk after the final right bclk rise.
// Backpr. : none; scoreboard pops one expected pair per sample_valid pulse.
module tb_i2s_rx;
  localparam int DATA_W      = 24;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i2s_bclk = 1'b0;
  logic              i2s_lrclk = 1'b1;
  logic              i2s_sdata = 1'b0;
  logic [DATA_W-1:0] sample_l, sample_r;
  logic              sample_valid, frame_err;

  i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] l; logic [23:0] r; logic lat; } exp_t;
  typedef struct { logic [23:0] l; logic [23:0] r; int nslot; int half; } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_bit_cyc = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  logic rst_q = 1'b1;
  logic [23:0] prev_l = '0, prev_r = '0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[6];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] trunc(input logic [23:0] w, input int n);
    logic [23:0] m;
    if (n >= 24) return w;
    m = '1;
    m = m << (24 - n);
    return w & m;
  endfunction

  // Monitor: scoreboard on each pulse, stability between pulses.
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (sample_valid) begin
      valid_cnt++;
      check("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("pair_l", 32'(sample_l), 32'(mon_e.l));
        check("pair_r", 32'(sample_r), 32'(mon_e.r));
        if (mon_e.lat) check("valid_latency", 32'(cyc - last_bit_cyc), 32'(SYNC_STAGES + 1));
      end
    end else if (!rst_q) begin
      check("hold_l", 32'(sample_l), 32'(prev_l));
      check("hold_r", 32'(sample_r), 32'(prev_r));
    end
    prev_l = sample_l;
    prev_r = sample_r;
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sample_l"}, 32'(sample_l), 32'd0);
    check({tag, "_sample_r"}, 32'(sample_r), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // One bit slot: data changes with bclk low, DUT samples on the rise.
  task automatic slot(input logic ws, input logic sd, input int half,
                      input logic mark, input logic do_rst);
    @(negedge clk);
    i2s_bclk  = 1'b0;
    i2s_lrclk = ws;
    i2s_sdata = sd;
    repeat (half - 1) @(negedge clk);
    i2s_bclk = 1'b1;
    if (mark) last_bit_cyc = cyc;
    if (do_rst) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_outputs_zero("mid_reset");
      if (half > 3) repeat (half - 3) @(negedge clk);
    end else begin
      repeat (half - 1) @(negedge clk);
    end
  endtask

  // Delay slot (data driven 1 and must be ignored), then nslot data slots.
  // Bits past the 24-bit word are padding driven 1 and must be ignored.
  task automatic send_chan(input logic ws, input logic [23:0] w, input int nslot,
                           input int half, input logic mark_last, input logic rst_msb);
    logic b;
    slot(ws, 1'b1, half, 1'b0, 1'b0);
    for (int i = 0; i < nslot; i++) begin
      b = (i < 24) ? w[23 - i] : 1'b1;
      slot(ws, b, half, mark_last && (i == 23), rst_msb && (i == 0));
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nslot,
                            input int half, input logic expect_pair, input logic rst_msb);
    exp_t e;
    if (expect_pair) begin
      e.l = trunc(l, nslot);
      e.r = trunc(r, nslot);
      e.lat = (nslot >= 24);
      sb.push_back(e);
    end
    send_chan(1'b0, l, nslot, half, 1'b0, rst_msb);
    send_chan(1'b1, r, nslot, half, nslot >= 24, 1'b0);
  endtask

  initial begin
    int exp_err, pend, vc0, ec0;
    logic [23:0] rl, rr;

    tbl[0] = '{24'h7FFFFF, 24'h800001, 32, 2};  // full-scale, 32-bit slots
    tbl[1] = '{24'hA5A500, 24'h5A5A00, 16, 2};  // 16-bit slots: short words
    tbl[2] = '{24'h123456, 24'hABCDEF, 32, 8};  // bclk = clk/16
    tbl[3] = '{24'h123456, 24'hABCDEF, 32, 2};  // same bits at clk/4
    tbl[4] = '{24'hFFFFFF, 24'h000000, 24, 2};  // slot exactly DATA_W
    tbl[5] = '{24'h000001, 24'hC00000, 20, 3};  // 20-bit slots: LSBs lost

    // Reset state
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Stream begins in the right channel; no output until ws falls.
    repeat (3) slot(1'b1, 1'b1, 2, 1'b0, 1'b0);
    check("preroll_no_valid", 32'(valid_cnt), 32'd0);

    exp_err = 0;
    pend = 0;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].l, tbl[i].r, tbl[i].nslot, tbl[i].half, 1'b1, 1'b0);
      exp_err += pend;
      pend = 0;
      if (tbl[i].nslot < 24) begin
        exp_err += 1;
        pend = 1;
      end
      check("frame_err_count", 32'(err_cnt), 32'(exp_err));
    end
    slot(1'b0, 1'b0, 2, 1'b0, 1'b0);  // ws fall closes the last short right word
    repeat (8) @(negedge clk);
    exp_err += pend;
    check("table_err_total", 32'(err_cnt), 32'(exp_err));
    check("table_valid_count", 32'(valid_cnt), 32'd6);
    check("table_sb_empty", 32'(sb.size()), 32'd0);

    // Reset released in the middle of a right word.
    vc0 = valid_cnt;
    ec0 = err_cnt;
    rst = 1'b1;
    repeat (3) slot(1'b1, 1'b1, 2, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (6) slot(1'b1, 1'b0, 2, 1'b0, 1'b0);
    check("no_valid_before_ws_fall", 32'(valid_cnt), 32'(vc0));
    send_frame(24'h123456, 24'hABCDEF, 32, 2, 1'b1, 1'b0);
    send_frame(24'h654321, 24'hFEDCBA, 32, 2, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    check("rstrel_valid_count", 32'(valid_cnt - vc0), 32'd2);
    check("rstrel_err", 32'(err_cnt), 32'(ec0));

    // 1-clk reset during left MSB of frame 3: frame 3 produces nothing.
    vc0 = valid_cnt;
    send_frame(24'h111111, 24'h222222, 32, 2, 1'b1, 1'b0);
    send_frame(24'h333333, 24'h444444, 32, 2, 1'b1, 1'b0);
    send_frame(24'h555555, 24'h666666, 32, 2, 1'b0, 1'b1);
    send_frame(24'h777777, 24'h888888, 32, 2, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    check("midrst_valid_count", 32'(valid_cnt - vc0), 32'd3);
    check("midrst_err", 32'(err_cnt), 32'(ec0));

    // 100 random frames at bclk = clk/4.
    vc0 = valid_cnt;
    for (int i = 0; i < 100; i++) begin
      rl = 24'($urandom);
      rr = 24'($urandom);
      send_frame(rl, rr, 32, 2, 1'b1, 1'b0);
    end
    repeat (8) @(negedge clk);
    check("random_valid_count", 32'(valid_cnt - vc0), 32'd100);
    check("random_err", 32'(err_cnt), 32'(ec0));
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
